// File: rtl/dc_blocker_mc_if.sv
// dc_blocker_mc_if: sample stream, control strobes and sticky status of the multichannel DC blocker
interface dc_blocker_mc_if #(
    parameter int WIDTH = 16,
    parameter int CW    = 1
);
    logic                    in_valid;
    logic signed [WIDTH-1:0] in_data;
    logic                    in_first;
    logic                    bypass;
    logic                    clear;
    logic                    out_valid;
    logic signed [WIDTH-1:0] out_data;
    logic [CW-1:0]           out_chan;
    logic                    sat;
    logic                    sync_err;
    modport master (
        output in_valid, in_data, in_first, bypass, clear,
        input  out_valid, out_data, out_chan, sat, sync_err
    );
    modport slave (
        input  in_valid, in_data, in_first, bypass, clear,
        output out_valid, out_data, out_chan, sat, sync_err
    );
endinterface

// File: rtl/dc_blocker_mc.sv
// dc_blocker_mc: time-multiplexed per-channel DC-blocking high-pass, y = x - x' + (1 - 2^-K) y'
module dc_blocker_mc #(
    parameter int  WIDTH    = 16,
    parameter int  CHANNELS = 2,
    parameter int  K        = 8,
    localparam int CW       = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
    input logic           clk,
    input logic           rst,
    dc_blocker_mc_if.slave bus
);
    localparam int AW = WIDTH + K + 2;
    localparam int RW = WIDTH + 2;
    logic signed [AW-1:0]    acc [CHANNELS];
    logic signed [WIDTH-1:0] x_prev [CHANNELS];
    logic [CW-1:0]           ch, c, ch_nxt;
    logic signed [WIDTH:0]   d;
    logic signed [AW-1:0]    acc_c, acc_new;
    logic signed [RW-1:0]    r;
    logic                    ov_hi, ov_lo;
    logic signed [WIDTH-1:0] y;
    logic                    s1_valid, s1_byp;
    logic signed [AW-1:0]    s1_acc;
    logic signed [WIDTH-1:0] s1_x;
    logic [CW-1:0]           s1_chan;
    always_comb begin
        c       = bus.in_first ? '0 : ch;
        ch_nxt  = c == CW'(CHANNELS - 1) ? '0 : c + 1'b1;
        acc_c   = acc[c];
        d       = {bus.in_data[WIDTH-1], bus.in_data} - {x_prev[c][WIDTH-1], x_prev[c]};
        acc_new = acc_c - (acc_c >>> K) + ($signed({{(AW-WIDTH-1){d[WIDTH]}}, d}) <<< K);
        r       = RW'((s1_acc + AW'(1 << (K - 1))) >>> K);
        ov_hi   = !r[RW-1] && (r[RW-2] || r[RW-3]);
        ov_lo   = r[RW-1] && !(r[RW-2] && r[RW-3]);
        y       = ov_hi ? {1'b0, {(WIDTH-1){1'b1}}} : ov_lo ? {1'b1, {(WIDTH-1){1'b0}}} : r[WIDTH-1:0];
    end
    // Stage 1 commits channel state so a back-to-back sample on the same channel sees it directly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc[i]    <= '0;
                x_prev[i] <= '0;
            end
            ch            <= '0;
            s1_valid      <= 1'b0;
            s1_byp        <= 1'b0;
            s1_acc        <= '0;
            s1_x          <= '0;
            s1_chan       <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_chan  <= '0;
            bus.sat       <= 1'b0;
            bus.sync_err  <= 1'b0;
        end else begin
            s1_valid <= bus.in_valid && !bus.clear;
            if (bus.clear) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    acc[i]    <= '0;
                    x_prev[i] <= '0;
                end
                ch <= '0;
            end else if (bus.in_valid) begin
                acc[c]    <= acc_new;
                x_prev[c] <= bus.in_data;
                ch        <= ch_nxt;
                s1_acc    <= acc_new;
                s1_x      <= bus.in_data;
                s1_byp    <= bus.bypass;
                s1_chan   <= c;
            end
            bus.out_valid <= s1_valid;
            if (s1_valid) begin
                bus.out_data <= s1_byp ? s1_x : y;
                bus.out_chan <= s1_chan;
            end
            bus.sat      <= !bus.clear && (bus.sat || (s1_valid && !s1_byp && (ov_hi || ov_lo)));
            bus.sync_err <= !bus.clear && (bus.sync_err || (bus.in_valid && bus.in_first && ch != '0));
        end
    end
endmodule

// File: doc/dc_blocker_mc.md
# dc_blocker_mc

Parametrised, time-multiplexed multichannel DC-blocking high-pass filter for the PCM audio path. It implements y[n] = x[n] − x[n−1] + (1 − 2^−K)·y[n−1] for each of CHANNELS interleaved streams. Each channel keeps its own state with K fractional guard bits. Outputs use round-to-nearest with saturation to WIDTH bits. The block sits between the PCM sample source and downstream DSP, and adds valid/channel tagging, bypass, state clear and error/saturation flags.

## Interface
- WIDTH, 16: signed PCM sample width.
- CHANNELS, 2: number of interleaved channels (≥1).
- K, 8: pole shift; pole = 1 − 2^−K; also the number of fractional accumulator bits (≥1).
- CW, derived, max(1, clog2(CHANNELS)): channel index width.

Ports:
- clk  in  1  sample-domain clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_data holds a sample this cycle.
- in_data  in  WIDTH  signed input sample.
- in_first  in  1  qualified by in_valid; marks the channel-0 sample of a frame.
- bypass  in  1  output equals the delayed input; state keeps updating.
- clear  in  1  synchronous one-cycle pulse; zeros all channel state and the channel counter.
- out_valid  out  1  out_data is valid.
- out_data  out  WIDTH  signed filtered (or bypassed) sample.
- out_chan  out  CW  channel index of out_data.
- sat  out  1  sticky; set when any output is clipped.
- sync_err  out  1  sticky; set when in_first arrives while the channel counter is nonzero.

## Operation
- Per-channel state: x_prev (WIDTH bits), acc (WIDTH+K+2 bits, signed, K fractional bits). Both are zero after reset or clear.
- Channel counter `ch`: each accepted sample uses index `ch`, then `ch` advances and wraps from CHANNELS−1 to 0. If in_first=1, the sample uses index 0 and `ch` becomes 1 (or 0 when CHANNELS=1). If in_first=1 while `ch`≠0, sync_err is set.
- Stage 1, on an accepted sample:
  - d = in_data − x_prev[c], computed at WIDTH+1 bits.
  - acc_new = acc[c] − (acc[c] >>> K) + (d <<< K), using an arithmetic shift.
  - acc[c] and x_prev[c] are written in the same cycle.
- Stage 2:
  - r = (acc_new + 2^(K−1)) >>> K.
  - Clip r to [−2^(WIDTH−1), 2^(WIDTH−1)−1]; any clip sets sat.
  - If bypass (sampled in stage 1) is set, the stage-2 result is the stage-1 input sample instead, and bypass never sets sat.
- The state update is complete within stage 1, so back-to-back samples on the same channel (including CHANNELS=1) need no forwarding.
- clear and in_valid in the same cycle: clear wins. The sample is dropped, state is zeroed, and nothing enters the pipeline. Samples already in stage 2 still emit.
- sat and sync_err are cleared only by rst or clear.

## Timing
- Latency is 2 cycles: a sample with in_valid at edge N produces out_valid=1 after edge N+2.
- Full throughput: one sample per cycle, no backpressure. Gaps in in_valid create matching gaps in out_valid.
- out_chan travels with its sample through both stages.
- Reset values: out_valid=0, out_data=0, out_chan=0, sat=0, sync_err=0. All acc and x_prev are 0, and `ch`=0.
- Reset asserted mid-stream: the pipeline is flushed immediately, and no out_valid appears for in-flight samples. The first sample after deassertion is treated as channel 0.
- Toggling bypass affects only samples accepted after the toggle. Filter state stays continuous across bypass periods.

## Test plan
- DC step, CHANNELS=2, K=8: ch0 constant 1000, ch1 constant 0 (interleaved, in_first on ch0).
  - ch0 outputs 1000, 996, 992, … decaying toward 0.
  - ch1 outputs all 0.
  - out_chan alternates 0,1.
  - out_valid lags in_valid by 2.
- Full-scale swing: ch0 receives −32768 then 32767.
  - Second output clips to 32767 and sat=1.
  - sat stays 1 until clear.
- Resync: with CHANNELS=2, assert in_first on what the counter treats as ch1.
  - sync_err=1.
  - That sample is tagged out_chan=0 and uses channel-0 state.
- Back-to-back single channel, CHANNELS=1: in_valid every cycle with 0, 256, 256.
  - Outputs are 0, 256, 255.
- Bypass: with bypass=1, input 1234 outputs 1234 after 2 cycles and sat is unaffected. After deasserting bypass, the next output follows the filter state updated during bypass.
- Reset and clear:
  - rst pulsed mid-frame: all outputs return to 0 immediately and no stale out_valid appears.
  - clear coincident with in_valid: the sample is dropped and the following sample of 500 outputs 500.
